// File: rtl/servant_flash_boot.sv
// Boot loader: copies WORDS words from SPI flash at BOOT_ADDR into RAM over a Wishbone
// write port, holding the CPU in reset and owning the SPI pins until the copy is done.
// state   | meaning
// S_IDLE  | one cycle after reset, decides between copy and no-copy
// S_CMD   | CS low, shifting out read opcode + 24-bit flash address
// S_DATA  | shifting in one 32-bit word
// S_WRITE | Wishbone write in flight, SPI paused with SCK low
// S_DONE  | CS high, CPU released, SPI pins handed over
module servant_flash_boot #(
    parameter logic [23:0] BOOT_ADDR = 24'h100000,
    parameter int unsigned WORDS     = 2048,
    parameter int unsigned CLK_DIV   = 2
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    output logic        o_cpu_hold,
    output logic        o_done,
    output logic        o_spi_en,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic        i_wb_ack,
    output logic        o_sck,
    output logic        o_csn,
    output logic        o_mosi,
    input  logic        i_miso
);

    localparam int IW = (WORDS == 0) ? 1 : $clog2(WORDS + 1);
    localparam int DW = (CLK_DIV <= 1) ? 1 : $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [IW-1:0] WORDS_W  = IW'(WORDS);
    localparam logic [31:0]   CMD_WORD = {8'h03, BOOT_ADDR};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [DW-1:0] div_q;
    logic [4:0]    bit_q;
    logic [31:0]   shift_q;
    logic [IW-1:0] idx_q;
    logic          sck_q, csn_q, mosi_q, cyc_q, done_q, hold_q, en_q;
    logic [31:0]   adr_q, dat_q;

    logic [31:0]   dat_d;
    logic [IW-1:0] idx_d;

    // Bytes arrive first-byte-first in the top of the shift register; RAM wants little-endian.
    assign dat_d = {shift_q[7:0], shift_q[15:8], shift_q[23:16], shift_q[31:24]};
    assign idx_d = idx_q + IW'(1);

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q <= S_IDLE;
            div_q   <= DIV_MAX;
            bit_q   <= 5'd0;
            shift_q <= 32'd0;
            idx_q   <= '0;
            sck_q   <= 1'b0;
            csn_q   <= 1'b1;
            mosi_q  <= 1'b0;
            cyc_q   <= 1'b0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
            en_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (WORDS == 0) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_CMD;
                        csn_q   <= 1'b0;
                        mosi_q  <= CMD_WORD[31];
                        shift_q <= CMD_WORD;
                        div_q   <= DIV_MAX;
                        bit_q   <= 5'd0;
                        sck_q   <= 1'b0;
                    end
                end
                S_CMD, S_DATA: begin
                    if (div_q != '0) begin
                        div_q <= div_q - DW'(1);
                    end else begin
                        div_q <= DIV_MAX;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                            if (state_q == S_DATA) shift_q <= {shift_q[30:0], i_miso};
                        end else begin
                            sck_q <= 1'b0;
                            bit_q <= bit_q + 5'd1;
                            // Command shifts in zeros, so MOSI settles to 0 after the last bit.
                            if (state_q == S_CMD) begin
                                shift_q <= {shift_q[30:0], 1'b0};
                                mosi_q  <= shift_q[30];
                            end
                            if (bit_q == 5'd31) begin
                                if (state_q == S_CMD) begin
                                    state_q <= S_DATA;
                                end else begin
                                    state_q <= S_WRITE;
                                    cyc_q   <= 1'b1;
                                    adr_q   <= 32'(idx_q) << 2;
                                    dat_q   <= dat_d;
                                end
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (i_wb_ack) begin
                        cyc_q <= 1'b0;
                        idx_q <= idx_d;
                        if (idx_d == WORDS_W) begin
                            state_q <= S_DONE;
                            csn_q   <= 1'b1;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                            en_q    <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                            div_q   <= DIV_MAX;
                        end
                    end
                end
                S_DONE: begin
                    csn_q  <= 1'b1;
                    sck_q  <= 1'b0;
                    mosi_q <= 1'b0;
                    cyc_q  <= 1'b0;
                    done_q <= 1'b1;
                    hold_q <= 1'b0;
                    en_q   <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_cpu_hold = hold_q;
    assign o_done     = done_q;
    assign o_spi_en   = en_q;
    assign o_wb_adr   = adr_q;
    assign o_wb_dat   = dat_q;
    assign o_wb_sel   = 4'hF;
    assign o_wb_we    = cyc_q;
    assign o_wb_cyc   = cyc_q;
    assign o_sck      = sck_q;
    assign o_csn      = csn_q;
    assign o_mosi     = mosi_q;

endmodule

// File: tb/tb_servant_flash_boot.sv
// Bench for servant_flash_boot: behavioural SPI flash and RAM models for three configurations.
module tb_servant_flash_boot;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    logic a_hold, a_done, a_en, a_we, a_cyc, a_sck, a_csn, a_mosi;
    logic [31:0] a_adr, a_dat;
    logic [3:0] a_sel;
    logic a_ack = 1'b0, a_miso = 1'b0;

    logic b_hold, b_done, b_en, b_we, b_cyc, b_sck, b_csn, b_mosi;
    logic [31:0] b_adr, b_dat;
    logic [3:0] b_sel;
    logic b_ack = 1'b0, b_miso = 1'b0;

    logic c_hold, c_done, c_en, c_we, c_cyc, c_sck, c_csn, c_mosi;
    logic [31:0] c_adr, c_dat;
    logic [3:0] c_sel;
    logic c_ack = 1'b0, c_miso = 1'b0;

    servant_flash_boot #(.BOOT_ADDR(24'h100000), .WORDS(4), .CLK_DIV(2)) u_a (
        .i_wb_clk(clk), .i_wb_rst(rst), .o_cpu_hold(a_hold), .o_done(a_done), .o_spi_en(a_en),
        .o_wb_adr(a_adr), .o_wb_dat(a_dat), .o_wb_sel(a_sel), .o_wb_we(a_we), .o_wb_cyc(a_cyc),
        .i_wb_ack(a_ack), .o_sck(a_sck), .o_csn(a_csn), .o_mosi(a_mosi), .i_miso(a_miso));

    servant_flash_boot #(.BOOT_ADDR(24'h100000), .WORDS(0), .CLK_DIV(2)) u_b (
        .i_wb_clk(clk), .i_wb_rst(rst), .o_cpu_hold(b_hold), .o_done(b_done), .o_spi_en(b_en),
        .o_wb_adr(b_adr), .o_wb_dat(b_dat), .o_wb_sel(b_sel), .o_wb_we(b_we), .o_wb_cyc(b_cyc),
        .i_wb_ack(b_ack), .o_sck(b_sck), .o_csn(b_csn), .o_mosi(b_mosi), .i_miso(b_miso));

    servant_flash_boot #(.BOOT_ADDR(24'hABCDEF), .WORDS(2), .CLK_DIV(1)) u_c (
        .i_wb_clk(clk), .i_wb_rst(rst), .o_cpu_hold(c_hold), .o_done(c_done), .o_spi_en(c_en),
        .o_wb_adr(c_adr), .o_wb_dat(c_dat), .o_wb_sel(c_sel), .o_wb_we(c_we), .o_wb_cyc(c_cyc),
        .i_wb_ack(c_ack), .o_sck(c_sck), .o_csn(c_csn), .o_mosi(c_mosi), .i_miso(c_miso));

    // Flash model: captures 32 command bits on rising SCK, then streams bytes MSB-first on falling SCK.
    logic [7:0]  a_mem [32];
    logic [7:0]  c_mem [32];
    int          a_bc = 0, c_bc = 0;
    logic [31:0] a_cmd = 32'd0, c_cmd = 32'd0;
    time         a_t1 = 0, a_t32 = 0, c_t1 = 0, c_t32 = 0;

    always @(posedge a_sck or negedge a_sck or posedge a_csn) begin
        if (a_csn === 1'b1) begin
            a_bc   = 0;
            a_miso = 1'b0;
        end else if (a_sck === 1'b1) begin
            a_bc++;
            if (a_bc <= 32) a_cmd = {a_cmd[30:0], a_mosi};
            if (a_bc == 1) a_t1 = $time;
            if (a_bc == 32) begin
                a_t32 = $time;
                check("a_cmd", a_cmd, 32'h03100000);
            end
        end else if (a_bc >= 32 && a_bc < 32 + 256) begin
            a_miso = a_mem[(a_bc - 32) / 8][7 - ((a_bc - 32) % 8)];
        end
    end

    always @(posedge c_sck or negedge c_sck or posedge c_csn) begin
        if (c_csn === 1'b1) begin
            c_bc   = 0;
            c_miso = 1'b0;
        end else if (c_sck === 1'b1) begin
            c_bc++;
            if (c_bc <= 32) c_cmd = {c_cmd[30:0], c_mosi};
            if (c_bc == 1) c_t1 = $time;
            if (c_bc == 32) begin
                c_t32 = $time;
                check("c_cmd", c_cmd, 32'h03ABCDEF);
            end
        end else if (c_bc >= 32 && c_bc < 32 + 256) begin
            c_miso = c_mem[(c_bc - 32) / 8][7 - ((c_bc - 32) % 8)];
        end
    end

    // RAM model: word 1 of A is stalled 5 cycles, other A words randomly; C always acks at once.
    int a_wr = 0, a_stall = 0, c_wr = 0;
    bit a_first = 1'b1;
    bit b_low = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            a_wr = 0; a_ack = 1'b0; a_first = 1'b1;
        end else if (a_cyc !== 1'b1) begin
            a_ack = 1'b0; a_first = 1'b1;
        end else begin
            if (a_first) begin
                a_first = 1'b0;
                a_stall = (a_wr == 1) ? 5 : int'($urandom_range(0, 3));
            end
            check("a_wr_range", 32'(a_wr < 4), 1);
            if (a_wr < 4) begin
                check("a_adr", a_adr, 32'(a_wr * 4));
                check("a_dat", a_dat, {a_mem[4*a_wr+3], a_mem[4*a_wr+2], a_mem[4*a_wr+1], a_mem[4*a_wr]});
            end
            if (a_stall == 0) begin
                a_ack = 1'b1;
                a_wr++;
            end else begin
                a_ack = 1'b0;
                a_stall--;
                check("a_stall_pins", 32'({a_we, a_sck, a_csn}), 32'h4);
            end
        end
    end

    always @(negedge clk) begin
        if (b_csn === 1'b0) b_low = 1'b1;
        if (rst) begin
            c_wr = 0; c_ack = 1'b0;
        end else if (c_cyc !== 1'b1) begin
            c_ack = 1'b0;
        end else begin
            check("c_wr_range", 32'(c_wr < 2), 1);
            if (c_wr < 2) begin
                check("c_adr", c_adr, 32'(c_wr * 4));
                check("c_dat", c_dat, {c_mem[4*c_wr+3], c_mem[4*c_wr+2], c_mem[4*c_wr+1], c_mem[4*c_wr]});
            end
            c_ack = 1'b1;
            c_wr++;
        end
    end

    int k, lat_b, lat_c;

    initial begin
        for (int i = 0; i < 32; i++) begin
            a_mem[i] = 8'(i);
            c_mem[i] = 8'($urandom);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_sck", 32'({a_sck, c_sck}), 0);
        end
        check("rst_ctl", 32'({a_hold, a_done, a_en, a_csn, a_sck, a_mosi, a_cyc, a_we}), 32'hB0);
        check("rst_adr", a_adr, 0);
        check("rst_dat", a_dat, 0);
        check("rst_sel", 32'(a_sel), 32'hF);
        check("rst_b", 32'({b_done, b_csn, b_hold}), 32'h3);

        // Run 1: fixed image 00..0F on A, latency of B and C.
        @(negedge clk); rst = 1'b0;
        k = 0; lat_b = 0; lat_c = 0;
        while (!(a_done === 1'b1 && c_done === 1'b1) && k < 3000) begin
            @(posedge clk); #1;
            k++;
            if (b_done === 1'b1 && lat_b == 0) lat_b = k;
            if (c_done === 1'b1 && lat_c == 0) lat_c = k;
        end
        check("lat_b", 32'(lat_b), 2);
        check("lat_c", 32'(lat_c), 195);
        check("b_csn_never_low", 32'(b_low), 0);
        check("a_fin", 32'({a_done, a_hold, a_csn, a_en}), 32'hA);
        check("c_fin", 32'({c_done, c_hold, c_csn, c_en}), 32'hA);
        check("a_words", 32'(a_wr), 4);
        check("c_words", 32'(c_wr), 2);
        check("a_sck_span", 32'(a_t32 - a_t1), 1240);
        check("c_sck_span", 32'(c_t32 - c_t1), 620);

        // Run 2: random image, aborted by reset after 10 data bits of word 2.
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a_mem[i] = 8'($urandom);
            c_mem[i] = 8'($urandom);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        k = 0;
        while (a_bc < 32 + 64 + 10 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("abort_point", 32'(a_bc == 32 + 64 + 10), 1);
        check("abort_words", 32'(a_wr), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_pins", 32'({a_csn, a_cyc, a_sck}), 32'h4);

        // Run 3: fresh random image, full rerun from word 0.
        for (int i = 0; i < 32; i++) begin
            a_mem[i] = 8'($urandom);
            c_mem[i] = 8'($urandom);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        k = 0;
        while (!(a_done === 1'b1 && c_done === 1'b1) && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        check("rerun_a_fin", 32'({a_done, a_hold, a_csn, a_en}), 32'hA);
        check("rerun_c_fin", 32'({c_done, c_hold, c_csn, c_en}), 32'hA);
        check("rerun_a_words", 32'(a_wr), 4);
        check("rerun_c_words", 32'(c_wr), 2);
        check("rerun_b_done", 32'({b_done, b_csn, b_hold}), 32'h6);
        check("b_csn_never_low_end", 32'(b_low), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
